// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready flow control.
// The word is split into STAGES segments. Stage k resolves segment k from the
// carry registered by stage k-1. The operand bits of later segments travel
// along unmodified until their own segment is reached.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int  DIV       = (STAGES >= 1 && GROUP >= 1) ? STAGES * GROUP : 1;
    localparam bit  PARAMS_OK = (STAGES >= 1) && (GROUP >= 1) && ((WIDTH % DIV) == 0);
    localparam int  SEG       = WIDTH / ((STAGES >= 1) ? STAGES : 1);
    localparam int  NGRP      = SEG / ((GROUP >= 1) ? GROUP : 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("pipelined_cla_addsub: need STAGES >= 1 and WIDTH %% (STAGES*GROUP) == 0");
    end

    // Carry into position n of a generate/propagate vector, written as a flat
    // sum of products so that no carry ripples from one position to the next.
    function automatic logic lookahead(input logic [SEG-1:0] g, input logic [SEG-1:0] p,
                                       input logic c0, input int n);
        logic c_acc;
        logic term;
        // NOTE: blocking assignments here build a combinational value step by
        // step; anything that must hold state across clocks uses <= instead.
        c_acc = c0;
        for (int m = 0; m < SEG; m++) begin
            if (m < n) c_acc = c_acc & p[m];
        end
        for (int i = 0; i < SEG; i++) begin
            if (i < n) begin
                term = g[i];
                for (int m = i + 1; m < SEG; m++) begin
                    if (m < n) term = term & p[m];
                end
                c_acc = c_acc | term;
            end
        end
        return c_acc;
    endfunction

    // One global stall: a held result freezes every stage, bubbles included.
    logic w_stall;
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : gen_seg
        localparam int REM = WIDTH - k * SEG;  // operand-B bits not yet consumed

        logic             w_valid_in;
        logic             w_c_in;
        logic             w_mode_in;
        logic [WIDTH-1:0] w_word_in;           // low: finished sum, high: pending A
        logic [REM-1:0]   w_b_rem;

        if (k == 0) begin : g_src
            assign w_valid_in = in_valid;
            assign w_c_in     = cin ^ mode;
            assign w_mode_in  = mode;
            assign w_word_in  = a;
            assign w_b_rem    = b;
        end else begin : g_src
            assign w_valid_in = gen_seg[k-1].r_valid;
            assign w_c_in     = gen_seg[k-1].r_carry;
            assign w_mode_in  = gen_seg[k-1].g_fwd.r_mode;
            assign w_word_in  = gen_seg[k-1].r_word;
            assign w_b_rem    = gen_seg[k-1].g_fwd.r_b_hi;
        end

        logic [SEG-1:0]   w_a_seg, w_b_seg, w_p, w_g, w_bit_c, w_sum_seg;
        logic [NGRP-1:0]  w_grp_g, w_grp_p, w_grp_c;
        logic             w_seg_cout;
        logic [WIDTH-1:0] w_word_next;

        // Two-level look-ahead: group G/P, group carries, then bit carries.
        always_comb begin
            // NOTE: every output gets a default first so no path can leave a
            // value unassigned and infer a latch.
            w_grp_g     = '0;
            w_grp_p     = '0;
            w_grp_c     = '0;
            w_bit_c     = '0;
            w_a_seg     = w_word_in[k*SEG +: SEG];
            w_b_seg     = w_b_rem[SEG-1:0] ^ {SEG{w_mode_in}};
            w_p         = w_a_seg ^ w_b_seg;
            w_g         = w_a_seg & w_b_seg;
            for (int j = 0; j < NGRP; j++) begin
                w_grp_g[j] = lookahead(SEG'(w_g[j*GROUP +: GROUP]), SEG'(w_p[j*GROUP +: GROUP]), 1'b0, GROUP);
                w_grp_p[j] = &w_p[j*GROUP +: GROUP];
            end
            for (int j = 0; j < NGRP; j++) begin
                w_grp_c[j] = lookahead(SEG'(w_grp_g), SEG'(w_grp_p), w_c_in, j);
            end
            for (int j = 0; j < NGRP; j++) begin
                for (int i = 0; i < GROUP; i++) begin
                    w_bit_c[j*GROUP+i] = lookahead(SEG'(w_g[j*GROUP +: GROUP]),
                                                   SEG'(w_p[j*GROUP +: GROUP]), w_grp_c[j], i);
                end
            end
            w_seg_cout  = lookahead(SEG'(w_grp_g), SEG'(w_grp_p), w_c_in, NGRP);
            w_sum_seg   = w_p ^ w_bit_c;
            w_word_next = w_word_in;
            w_word_next[k*SEG +: SEG] = w_sum_seg;
        end

        logic             r_valid;
        logic             r_carry;
        logic [WIDTH-1:0] r_word;

        // Stage register: advances as a whole unless the output is held.
        always_ff @(posedge clk or posedge rst) begin
            // NOTE: datapath registers are reset too, so the outputs read as
            // zero during reset rather than showing stale operands.
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_word  <= '0;
            end else if (!w_stall) begin
                r_valid <= w_valid_in;
                r_carry <= w_seg_cout;
                r_word  <= w_word_next;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic                 r_mode;
            logic [REM-SEG-1:0]   r_b_hi;

            // Carry mode and the still-unused upper B bits to the next segment.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mode <= 1'b0;
                    r_b_hi <= '0;
                end else if (!w_stall) begin
                    r_mode <= w_mode_in;
                    r_b_hi <= w_b_rem[REM-1:SEG];
                end
            end
        end else begin : g_last
            logic r_overflow;
            logic r_zero;
            logic r_negative;

            // Status flags registered alongside the completed sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_overflow <= 1'b0;
                    r_zero     <= 1'b0;
                    r_negative <= 1'b0;
                end else if (!w_stall) begin
                    r_overflow <= w_bit_c[SEG-1] ^ w_seg_cout;
                    r_zero     <= ~|w_word_next;
                    r_negative <= w_word_next[WIDTH-1];
                end
            end
        end
    end

    assign out_valid = gen_seg[STAGES-1].r_valid;
    assign sum       = gen_seg[STAGES-1].r_word;
    assign cout      = gen_seg[STAGES-1].r_carry;
    assign overflow  = gen_seg[STAGES-1].g_last.r_overflow;
    assign zero      = gen_seg[STAGES-1].g_last.r_zero;
    assign negative  = gen_seg[STAGES-1].g_last.r_negative;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: a 32-bit/2-stage instance for directed
// cases and a 64-bit/4-stage instance for a randomized sweep, both checked
// against an arithmetic reference model.
module tb_pipelined_cla_addsub;
    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        res_t r;
        int   stamp;
    } exp_t;

    logic clk;
    logic rst;

    logic        iv32, ir32, cin32, mode32, ov32, or32, cout32, ovf32, zero32, neg32;
    logic [31:0] a32, b32, sum32;
    logic        iv64, ir64, cin64, mode64, ov64, or64, cout64, ovf64, zero64, neg64;
    logic [63:0] a64, b64, sum64;

    int n_checks = 0;
    int n_errors = 0;

    pipelined_cla_addsub #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .mode(mode32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(cout32), .overflow(ovf32), .zero(zero32), .negative(neg32)
    );

    pipelined_cla_addsub #(.WIDTH(64), .GROUP(4), .STAGES(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin64), .mode(mode64), .out_valid(ov64), .out_ready(or64), .sum(sum64),
        .cout(cout64), .overflow(ovf64), .zero(zero64), .negative(neg64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: modular sum of A and the effective B, with signed overflow
    // decided by whether the exact signed result fits in w bits.
    function automatic res_t ref_model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                       input logic ci, input logic mi);
        logic [63:0] mask, av, bv, ax, bx;
        logic [64:0] full;
        logic [65:0] s, hi, ones;
        logic        ce;
        res_t        r;
        mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        av     = ai & mask;
        bv     = (mi ? ~bi : bi) & mask;
        ce     = ci ^ mi;
        full   = {1'b0, av} + {1'b0, bv} + 65'(ce);
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        ax     = av[w-1] ? (av | ~mask) : av;
        bx     = bv[w-1] ? (bv | ~mask) : bv;
        s      = {{2{ax[63]}}, ax} + {{2{bx[63]}}, bx} + 66'(ce);
        hi     = s >> (w - 1);
        ones   = {66{1'b1}} >> (w - 1);
        r.ovf  = (hi != 66'd0) && (hi != ones);
        r.zero = (r.sum == 64'd0);
        r.neg  = r.sum[w-1];
        return r;
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboards: push on input handshake, pop and compare on output handshake.
    // adv counts advancing edges, so adv - stamp is the unstalled latency.
    bit   mon32_en = 1'b0;
    bit   mon64_en = 1'b0;
    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int   adv32 = 0, adv64 = 0, rx32 = 0, rx64 = 0;

    always @(negedge clk) begin
        #2;
        if (mon32_en) begin
            if (ov32 && or32) begin
                if (q32.size() == 0) begin
                    check("m32_unexpected_result", 64'(sum32), 64'hDEAD);
                end else begin
                    e32 = q32.pop_front();
                    rx32++;
                    check("m32_sum", 64'(sum32), e32.r.sum);
                    check("m32_cout", 64'(cout32), 64'(e32.r.cout));
                    check("m32_ovf", 64'(ovf32), 64'(e32.r.ovf));
                    check("m32_lat", 64'(adv32 - e32.stamp), 64'd2);
                end
            end
            if (iv32 && ir32) q32.push_back('{r: ref_model(32, {32'd0, a32}, {32'd0, b32}, cin32, mode32), stamp: adv32});
            if (ir32) adv32++;
        end
        if (mon64_en) begin
            if (ov64 && or64) begin
                if (q64.size() == 0) begin
                    check("m64_unexpected_result", sum64, 64'hDEAD);
                end else begin
                    e64 = q64.pop_front();
                    rx64++;
                    check("m64_sum", sum64, e64.r.sum);
                    check("m64_flags", 64'({cout64, ovf64, zero64, neg64}),
                          64'({e64.r.cout, e64.r.ovf, e64.r.zero, e64.r.neg}));
                    check("m64_lat", 64'(adv64 - e64.stamp), 64'd4);
                end
            end
            if (iv64 && ir64) q64.push_back('{r: ref_model(64, a64, b64, cin64, mode64), stamp: adv64});
            if (ir64) adv64++;
        end
    end

    // Single beat through the 32-bit instance with an unstalled output.
    task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic tm, input logic [31:0] exp_sum);
        res_t r;
        r = ref_model(32, {32'd0, ta}, {32'd0, tb}, tc, tm);
        @(negedge clk);
        a32 = ta; b32 = tb; cin32 = tc; mode32 = tm; iv32 = 1'b1; or32 = 1'b1;
        #2 check({tag, "_in_ready"}, 64'(ir32), 64'd1);
        @(negedge clk);
        iv32 = 1'b0;
        #2 check({tag, "_not_yet_valid"}, 64'(ov32), 64'd0);
        @(negedge clk);
        #2;
        check({tag, "_valid"}, 64'(ov32), 64'd1);
        check({tag, "_sum"}, 64'(sum32), 64'(exp_sum));
        check({tag, "_cout"}, 64'(cout32), 64'(r.cout));
        check({tag, "_ovf"}, 64'(ovf32), 64'(r.ovf));
        check({tag, "_zero"}, 64'(zero32), 64'(r.zero));
        check({tag, "_neg"}, 64'(neg32), 64'(r.neg));
    endtask

    initial begin
        int  sent;
        int  guard;
        bit  hs_prev;

        rst = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; mode32 = 1'b0; or32 = 1'b1;
        iv64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; mode64 = 1'b0; or64 = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", 64'(ov32), 64'd0);
        check("rst_sum", 64'(sum32), 64'd0);
        check("rst_flags", 64'({cout32, ovf32, zero32, neg32}), 64'd0);
        check("rst_in_ready", 64'(ir32), 64'd1);
        check("rst64_out_valid", 64'(ov64), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases
        run32("full_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000);
        check("full_carry_cout_const", 64'(cout32), 64'd1);
        check("full_carry_zero_const", 64'(zero32), 64'd1);
        run32("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF);
        check("sub_ovf_const", 64'(ovf32), 64'd1);
        run32("sub_neg", 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE);
        check("sub_neg_cout_const", 64'(cout32), 64'd0);
        run32("seg_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001);
        run32("seg_borrow", 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_FFFF);

        // Streaming with backpressure: 1+1, 2+2, 3+3, 4+4
        @(negedge clk);
        q32.delete(); rx32 = 0; adv32 = 0; mon32_en = 1'b1;
        iv32 = 1'b1; cin32 = 1'b0; mode32 = 1'b0; or32 = 1'b1; a32 = 32'd1; b32 = 32'd1;
        @(negedge clk);
        a32 = 32'd2; b32 = 32'd2;
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd3; or32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #2;
            check("stall_in_ready", 64'(ir32), 64'd0);
            check("stall_valid", 64'(ov32), 64'd1);
            check("stall_sum_hold", 64'(sum32), 64'd2);
        end
        @(negedge clk);
        or32 = 1'b1;
        #2 check("stall_release_in_ready", 64'(ir32), 64'd1);
        @(negedge clk);
        a32 = 32'd4; b32 = 32'd4;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("stream_count", 64'(rx32), 64'd4);
        check("stream_queue_empty", 64'(q32.size()), 64'd0);
        mon32_en = 1'b0;

        // Asynchronous reset with two beats in flight
        @(negedge clk);
        a32 = 32'd10; b32 = 32'd20; iv32 = 1'b1;
        @(negedge clk);
        a32 = 32'd30; b32 = 32'd40;
        @(negedge clk);
        iv32 = 1'b0;
        #2 check("rst_mid_pre_valid", 64'(ov32), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(ov32), 64'd0);
        check("rst_mid_sum", 64'(sum32), 64'd0);
        check("rst_mid_flags", 64'({cout32, ovf32, zero32, neg32}), 64'd0);
        check("rst_mid_in_ready", 64'(ir32), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        run32("post_rst", 32'd7, 32'd8, 1'b0, 1'b0, 32'd15);

        // Randomized sweep on the 64-bit / 4-stage instance
        q64.delete(); rx64 = 0; adv64 = 0; mon64_en = 1'b1;
        sent = 0; guard = 0; hs_prev = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            @(negedge clk);
            guard++;
            or64 = ($urandom_range(0, 3) != 0);
            if (!iv64 || hs_prev) begin
                if ($urandom_range(0, 7) != 0) begin
                    iv64   = 1'b1;
                    a64    = pick64();
                    b64    = pick64();
                    cin64  = 1'($urandom_range(0, 1));
                    mode64 = 1'($urandom_range(0, 1));
                end else begin
                    iv64 = 1'b0;
                end
            end
            #1;
            hs_prev = iv64 && ir64;
            if (hs_prev) sent++;
        end
        check("sweep_sent", 64'(sent), 64'd1000);
        @(negedge clk);
        iv64 = 1'b0;
        or64 = 1'b1;
        for (int i = 0; i < 50 && q64.size() != 0; i++) @(negedge clk);
        #3;
        check("sweep_received", 64'(rx64), 64'd1000);
        check("sweep_queue_empty", 64'(q64.size()), 64'd0);
        mon64_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
